// File: rtl/floppy_sector_stream.sv
// Byte stream under the head: ID-field bytes during the header, sector-buffer bytes during data.
// Define FLOPPY_STREAM_CRC_EN to generate the MFM CRCs; otherwise CRC bytes are 00 and data_crc is 0.
module floppy_sector_stream #(
    parameter int SIDE_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dclk_en,
    input  logic                 sector_hdr,
    input  logic                 sector_data,
    input  logic [6:0]           track,
    input  logic [4:0]           sector,
    input  logic [SIDE_BITS-1:0] side,
    input  logic [10:0]          sector_len,
    output logic                 buf_rd,
    output logic [9:0]           buf_addr,
    output logic [4:0]           buf_sector,
    input  logic [7:0]           buf_q,
    output logic [7:0]           dout,
    output logic                 dout_valid,
    output logic                 dout_hdr,
    output logic                 dout_last,
    output logic [15:0]          data_crc
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t                 state, state_nx;
    logic                   enter_hdr, step_hdr, enter_data, step_data;
    logic [6:0]             trk_l;
    logic [SIDE_BITS-1:0]   side_l;
    logic [4:0]             sec_l;
    logic [1:0]             size_l;
    logic [10:0]            len_l;
    logic [2:0]             idx;
    logic [10:0]            didx, d_cur;
    logic                   d_in_range, d_is_last;
    logic [7:0]             pf;
    logic                   cap_p1, rd_pend;
    logic [7:0]             hdr_byte;
    logic [15:0]            hcrc_q;

    function automatic logic [1:0] size_code(input logic [10:0] len);
        case (len)
            11'd128:  size_code = 2'd0;
            11'd256:  size_code = 2'd1;
            11'd1024: size_code = 2'd3;
            default:  size_code = 2'd2;
        endcase
    endfunction

    always_comb begin
        state_nx   = state;
        enter_hdr  = 1'b0;
        step_hdr   = 1'b0;
        enter_data = 1'b0;
        step_data  = 1'b0;
        if (dclk_en) begin
            if (sector_hdr) begin
                state_nx = S_HDR;
                if (state == S_HDR) step_hdr = 1'b1;
                else                enter_hdr = 1'b1;
            end else if (sector_data) begin
                case (state)
                    S_HDR: begin
                        state_nx   = S_DATA;
                        enter_data = 1'b1;
                    end
                    S_DATA:  step_data = 1'b1;
                    default: state_nx = state;
                endcase
            end else begin
                state_nx = S_IDLE;
            end
        end
    end

    always_comb begin
        d_cur      = enter_data ? 11'd0 : didx;
        d_in_range = d_cur < len_l;
        d_is_last  = d_cur == (len_l - 11'd1);
        case (idx)
            3'd0:    hdr_byte = {1'b0, trk_l};
            3'd1:    hdr_byte = 8'(side_l);
            3'd2:    hdr_byte = {3'b000, sec_l};
            3'd3:    hdr_byte = {6'b000000, size_l};
            3'd4:    hdr_byte = hcrc_q[15:8];
            3'd5:    hdr_byte = hcrc_q[7:0];
            default: hdr_byte = 8'h4E;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Stage p0 -> p1: byte emission, buffer read strobes and prefetch capture
    always_ff @(posedge clk) begin
        if (reset) begin
            trk_l      <= '0;
            side_l     <= '0;
            sec_l      <= '0;
            size_l     <= '0;
            len_l      <= '0;
            idx        <= '0;
            didx       <= '0;
            pf         <= '0;
            cap_p1     <= 1'b0;
            rd_pend    <= 1'b0;
            buf_rd     <= 1'b0;
            buf_addr   <= '0;
            buf_sector <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_hdr   <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            buf_rd     <= 1'b0;
            dout_valid <= 1'b0;
            dout_hdr   <= 1'b0;
            dout_last  <= 1'b0;
            rd_pend    <= 1'b0;
            // buf_q belongs to the read issued one clk earlier
            cap_p1     <= buf_rd;
            if (cap_p1) pf <= buf_q;
            if (rd_pend) begin
                buf_rd   <= 1'b1;
                buf_addr <= didx[9:0];
            end
            if (enter_hdr) begin
                trk_l      <= track;
                side_l     <= side;
                sec_l      <= sector;
                size_l     <= size_code(sector_len);
                len_l      <= sector_len;
                idx        <= 3'd1;
                dout       <= {1'b0, track};
                dout_valid <= 1'b1;
                dout_hdr   <= 1'b1;
            end else if (step_hdr) begin
                dout       <= hdr_byte;
                dout_valid <= 1'b1;
                dout_hdr   <= 1'b1;
                dout_last  <= (idx == 3'd5);
                if (idx != 3'd7) idx <= idx + 3'd1;
                if (idx == 3'd5) begin
                    buf_rd     <= 1'b1;
                    buf_addr   <= '0;
                    buf_sector <= sec_l;
                end
            end else if (enter_data || step_data) begin
                dout_valid <= 1'b1;
                if (d_in_range) begin
                    dout      <= pf;
                    dout_last <= d_is_last;
                    rd_pend   <= !d_is_last;
                end else begin
                    dout <= 8'h00;
                end
                if (d_cur != 11'h7FF) didx <= d_cur + 11'd1;
            end
        end
    end

`ifdef FLOPPY_STREAM_CRC_EN
    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    localparam logic [15:0] DATA_SEED =
        crc_byte(crc_byte(crc_byte(crc_byte(16'hFFFF, 8'hA1), 8'hA1), 8'hA1), 8'hFB);

    logic [15:0] hcrc, dcrc;
    logic [3:0]  hcnt;
    logic [7:0]  hseq_byte;
    logic        done_p1;

    always_comb begin
        case (hcnt[2:0])
            3'd3:    hseq_byte = 8'hFE;
            3'd4:    hseq_byte = {1'b0, trk_l};
            3'd5:    hseq_byte = 8'(side_l);
            3'd6:    hseq_byte = {3'b000, sec_l};
            3'd7:    hseq_byte = {6'b000000, size_l};
            default: hseq_byte = 8'hA1;
        endcase
    end

    // Stage p1 -> p2: header CRC walks the latched ID one byte per clk; data CRC publishes after the last byte
    always_ff @(posedge clk) begin
        if (reset) begin
            hcrc     <= 16'hFFFF;
            dcrc     <= 16'hFFFF;
            hcnt     <= 4'd8;
            done_p1  <= 1'b0;
            data_crc <= '0;
        end else begin
            done_p1 <= 1'b0;
            if (enter_hdr) begin
                hcrc <= 16'hFFFF;
                hcnt <= 4'd0;
            end else if (hcnt != 4'd8) begin
                hcrc <= crc_byte(hcrc, hseq_byte);
                hcnt <= hcnt + 4'd1;
            end
            if ((enter_data || step_data) && d_in_range) begin
                dcrc    <= crc_byte(enter_data ? DATA_SEED : dcrc, pf);
                done_p1 <= d_is_last;
            end
            if (done_p1) data_crc <= dcrc;
        end
    end

    assign hcrc_q = hcrc;
`else
    assign hcrc_q   = 16'h0000;
    assign data_crc = 16'h0000;
`endif

endmodule
